// File: rtl/spwm_carrier_compare.sv
// spwm_carrier_compare
//   Sine-PWM modulator. The divided clock from the divider stage is
//   synchronised and turned into a single-cycle step enable. Each step moves a
//   symmetric triangle carrier. The carrier is compared against a sine sample
//   fetched from an external registered ROM. The compare result drives a
//   complementary high/low gate pair through a dead-time FSM.
//
// Ports
//   clk_in       : system clock
//   rst          : asynchronous active-high reset
//   en           : run enable (synchronous; low parks everything)
//   tick_src     : divided clock, asynchronous to clk_in
//   sample_data  : ROM data, valid one cycle after sample_addr
//   sample_addr  : ROM address, one sample per carrier period
//   carrier      : current carrier value (debug)
//   period_start : one-cycle pulse at each carrier valley
//   pwm_h/pwm_l  : high-side / low-side gate drives, never both high
`timescale 1ns/1ps
module spwm_carrier_compare #(
  parameter int CNT_W       = 8,
  parameter int CARRIER_MAX = 199,
  parameter int ADDR_W      = 6,
  parameter int DEADTIME    = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              tick_src,
  input  logic [CNT_W-1:0]  sample_data,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [CNT_W-1:0]  carrier,
  output logic              period_start,
  output logic              pwm_h,
  output logic              pwm_l
);

  localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(CARRIER_MAX);
  // Compare value one above the peak keeps carrier < cmp true all period.
  localparam logic [CNT_W-1:0] C_TOP   = CNT_W'(CARRIER_MAX + 1);
  localparam logic [7:0]       DT_LOAD = 8'(DEADTIME - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_DEAD_TO_L,
    S_L_ON,
    S_DEAD_TO_H,
    S_H_ON
  } state_t;

  // ---------------------------------------------------------------------------
  // Tick synchroniser: 2-FF sync plus a previous-value flop for edge detect.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       tick;

  assign sync_d = {sync_q[0], tick_src};
  assign prev_d = sync_q[1];
  assign tick   = sync_q[1] & ~prev_q;

  // ---------------------------------------------------------------------------
  // Carrier, sample address and compare registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  carrier_q, carrier_d;
  logic              dir_up_q, dir_up_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cmp_active_q, cmp_active_d;
  logic [CNT_W-1:0]  cmp_shadow_q, cmp_shadow_d;
  logic              period_start_q, period_start_d;
  // vld_pipe_q[0]: address just changed, [1]: ROM data for it is valid now.
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic              raw_q, raw_d;
  logic [CNT_W-1:0]  sample_clamped;
  logic [CNT_W-1:0]  carrier_inc, carrier_dec;

  assign carrier_inc    = carrier_q + CNT_W'(1);
  assign carrier_dec    = carrier_q - CNT_W'(1);
  assign sample_clamped = (sample_data > C_TOP) ? C_TOP : sample_data;
  assign raw_d          = (carrier_q < cmp_active_q);

  always_comb begin
    carrier_d      = carrier_q;
    dir_up_d       = dir_up_q;
    addr_d         = addr_q;
    cmp_active_d   = cmp_active_q;
    period_start_d = 1'b0;
    vld_pipe_d     = {vld_pipe_q[0], 1'b0};
    cmp_shadow_d   = vld_pipe_q[1] ? sample_clamped : cmp_shadow_q;

    if (!en) begin
      carrier_d     = '0;
      dir_up_d      = 1'b1;
      addr_d        = '0;
      cmp_active_d  = '0;
      // Keep re-reading address 0 so the shadow is ready when en returns.
      vld_pipe_d[0] = 1'b1;
    end else if (tick) begin
      if (dir_up_q) begin
        carrier_d = carrier_inc;
        if (carrier_inc == C_MAX) dir_up_d = 1'b0;
      end else begin
        carrier_d = carrier_dec;
        if (carrier_q == CNT_W'(1)) begin
          // Valley: swap in the new compare and fetch the next sample.
          dir_up_d       = 1'b1;
          period_start_d = 1'b1;
          cmp_active_d   = cmp_shadow_q;
          addr_d         = addr_q + ADDR_W'(1);
          vld_pipe_d[0]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      carrier_q      <= '0;
      dir_up_q       <= 1'b1;
      addr_q         <= '0;
      cmp_active_q   <= '0;
      cmp_shadow_q   <= '0;
      period_start_q <= 1'b0;
      // Address 0 is presented during reset; capture it right after release.
      vld_pipe_q     <= 2'b01;
      raw_q          <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      carrier_q      <= carrier_d;
      dir_up_q       <= dir_up_d;
      addr_q         <= addr_d;
      cmp_active_q   <= cmp_active_d;
      cmp_shadow_q   <= cmp_shadow_d;
      period_start_q <= period_start_d;
      vld_pipe_q     <= vld_pipe_d;
      raw_q          <= raw_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dead-time FSM. Outputs are registered and derived from the state being
  // entered, so both gates can only be high in the two ON states.
  // A dead interval only ends into the side matching raw_q at that moment;
  // otherwise it restarts toward the other side with a full reload.
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [7:0] dt_q;
  logic       pwm_h_q, pwm_l_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      dt_q    <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
      if (!en) begin
        state_q <= S_OFF;
        dt_q    <= '0;
      end else begin
        case (state_q)
          S_OFF: begin
            state_q <= S_DEAD_TO_L;
            dt_q    <= DT_LOAD;
          end
          S_DEAD_TO_L: begin
            if (dt_q != '0) begin
              dt_q <= dt_q - 8'd1;
            end else if (raw_q) begin
              state_q <= S_DEAD_TO_H;
              dt_q    <= DT_LOAD;
            end else begin
              state_q <= S_L_ON;
              pwm_l_q <= 1'b1;
            end
          end
          S_L_ON: begin
            if (raw_q) begin
              state_q <= S_DEAD_TO_H;
              dt_q    <= DT_LOAD;
            end else begin
              pwm_l_q <= 1'b1;
            end
          end
          S_DEAD_TO_H: begin
            if (dt_q != '0) begin
              dt_q <= dt_q - 8'd1;
            end else if (!raw_q) begin
              state_q <= S_DEAD_TO_L;
              dt_q    <= DT_LOAD;
            end else begin
              state_q <= S_H_ON;
              pwm_h_q <= 1'b1;
            end
          end
          S_H_ON: begin
            if (!raw_q) begin
              state_q <= S_DEAD_TO_L;
              dt_q    <= DT_LOAD;
            end else begin
              pwm_h_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_OFF;
            dt_q    <= '0;
          end
        endcase
      end
    end
  end

  assign sample_addr  = addr_q;
  assign carrier      = carrier_q;
  assign period_start = period_start_q;
  assign pwm_h        = pwm_h_q;
  assign pwm_l        = pwm_l_q;

endmodule

// File: tb/tb_spwm_carrier_compare.sv
// Bench for spwm_carrier_compare: directed vector table on the default
// configuration plus hand sequences for latency, duty windows, clamp, dead
// time glitch, en/rst behaviour, and an address-wrap run on a small-carrier
// instance (CARRIER_MAX=7) so 64+ periods fit in a short run.
`timescale 1ns/1ps
module tb_spwm_carrier_compare;

  logic       clk = 1'b0;
  logic       rst, en, tick_src, en2, tick_src2;
  logic [7:0] rom_val;
  logic [7:0] sample_data, sample_data2;
  logic [5:0] sample_addr, sample_addr2;
  logic [7:0] carrier, carrier2;
  logic       period_start, period_start2;
  logic       pwm_h, pwm_l, pwm_h2, pwm_l2;

  always #5 clk = ~clk;

  // Registered ROM models: main returns a constant, small returns its address.
  always @(posedge clk) begin
    sample_data  <= rom_val;
    sample_data2 <= {2'b00, sample_addr2};
  end

  spwm_carrier_compare u_dut (
    .clk_in(clk), .rst(rst), .en(en), .tick_src(tick_src),
    .sample_data(sample_data), .sample_addr(sample_addr), .carrier(carrier),
    .period_start(period_start), .pwm_h(pwm_h), .pwm_l(pwm_l)
  );

  spwm_carrier_compare #(.CARRIER_MAX(7)) u_small (
    .clk_in(clk), .rst(rst), .en(en2), .tick_src(tick_src2),
    .sample_data(sample_data2), .sample_addr(sample_addr2), .carrier(carrier2),
    .period_start(period_start2), .pwm_h(pwm_h2), .pwm_l(pwm_l2)
  );

  // Monitor: per-period high-time windows (period_start cycle inclusive),
  // both-off cycle count, overlap count.
  int ps_cnt = 0, h_cnt = 0, l_cnt = 0, last_h = 0, last_l = 0;
  int ps2_cnt = 0, h2_cnt = 0, l2_cnt = 0, last_h2 = 0, last_l2 = 0;
  int zero_cnt = 0, overlap_cnt = 0;

  always @(negedge clk) begin
    if ((pwm_h && pwm_l) || (pwm_h2 && pwm_l2)) overlap_cnt <= overlap_cnt + 1;
    if (!pwm_h && !pwm_l) zero_cnt <= zero_cnt + 1;
    if (period_start) begin
      ps_cnt <= ps_cnt + 1;
      last_h <= h_cnt;
      last_l <= l_cnt;
      h_cnt  <= int'(pwm_h);
      l_cnt  <= int'(pwm_l);
    end else begin
      h_cnt <= h_cnt + int'(pwm_h);
      l_cnt <= l_cnt + int'(pwm_l);
    end
    if (period_start2) begin
      ps2_cnt <= ps2_cnt + 1;
      last_h2 <= h2_cnt;
      last_l2 <= l2_cnt;
      h2_cnt  <= int'(pwm_h2);
      l2_cnt  <= int'(pwm_l2);
    end else begin
      h2_cnt <= h2_cnt + int'(pwm_h2);
      l2_cnt <= l2_cnt + int'(pwm_l2);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One tick_src period of sp cycles; entered and left #1 after a posedge.
  task automatic tick1(input int sp);
    tick_src = 1'b1;
    repeat (sp / 2) @(posedge clk);
    #1 tick_src = 1'b0;
    repeat (sp - sp / 2) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input int sp);
    for (int i = 0; i < n; i++) tick1(sp);
  endtask

  task automatic ticks2(input int n, input int sp);
    for (int i = 0; i < n; i++) begin
      tick_src2 = 1'b1;
      repeat (sp / 2) @(posedge clk);
      #1 tick_src2 = 1'b0;
      repeat (sp - sp / 2) @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int   n;     // ticks to apply (spacing 20)
    int   car;   // expected carrier afterwards
    int   addr;  // expected sample_addr
    int   ps;    // expected period_start pulses since reset
    logic h;     // expected pwm_h
    logic l;     // expected pwm_l
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int z0, l0;
    // Carrier starts at 1 after the latency check; cmp=100 from period 2 on.
    tbl[0] = '{198, 199, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{  1, 198, 0, 0, 1'b0, 1'b1};
    tbl[2] = '{197,   1, 0, 0, 1'b0, 1'b1};
    tbl[3] = '{  1,   0, 1, 1, 1'b1, 1'b0};
    tbl[4] = '{ 99,  99, 1, 1, 1'b1, 1'b0};
    tbl[5] = '{  1, 100, 1, 1, 1'b0, 1'b1};
    tbl[6] = '{ 99, 199, 1, 1, 1'b0, 1'b1};
    tbl[7] = '{100,  99, 1, 1, 1'b1, 1'b0};
    tbl[8] = '{ 98,   1, 1, 1, 1'b1, 1'b0};
    tbl[9] = '{  1,   0, 2, 2, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    tick_src = 1'b0; tick_src2 = 1'b0; rom_val = 8'd100;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_carrier", int'(carrier), 0);
    chk("rst_addr", int'(sample_addr), 0);
    chk("rst_pwm_h", int'(pwm_h), 0);
    chk("rst_pwm_l", int'(pwm_l), 0);
    chk("rst_period_start", int'(period_start), 0);

    // Idle: OFF -> DEAD_TO_L on first edge, L_ON four edges later
    @(posedge clk); #1 rst = 1'b0; en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_dead_l", int'(pwm_l), 0);
    @(posedge clk); @(negedge clk);
    chk("idle_l_on", int'(pwm_l), 1);
    chk("idle_h_off", int'(pwm_h), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_carrier", int'(carrier), 0);

    // Tick latency: carrier moves on the third edge after tick_src rises
    tick_src = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("tick_lat_edge2", int'(carrier), 0);
    @(posedge clk);
    #1 chk("tick_lat_edge3", int'(carrier), 1);
    tick_src = 1'b0;
    repeat (17) @(posedge clk);
    #1;

    // Vector table: carrier shape, valleys, address, gate side
    for (int i = 0; i < 10; i++) begin
      ticks(tbl[i].n, 20);
      chk($sformatf("vec%0d_carrier", i), int'(carrier), tbl[i].car);
      chk($sformatf("vec%0d_addr", i), int'(sample_addr), tbl[i].addr);
      chk($sformatf("vec%0d_ps", i), ps_cnt, tbl[i].ps);
      chk($sformatf("vec%0d_h", i), int'(pwm_h), int'(tbl[i].h));
      chk($sformatf("vec%0d_l", i), int'(pwm_l), int'(tbl[i].l));
    end

    // Steady duty with cmp=100: 199 ticks of 20 cycles high, minus dead time
    ticks(398, 20);
    chk("duty_ps", ps_cnt, 3);
    chk("duty_h", last_h, 3976);
    chk("duty_l", last_l, 3976);

    // Clamp: 255 -> 200, active two valleys later, high all period
    rom_val = 8'd255;
    ticks(3 * 398, 4);
    chk("clamp_ps", ps_cnt, 6);
    chk("clamp_h", last_h, 1592);
    chk("clamp_l", last_l, 0);

    // Zero: first zero period has the H->L switch, the next is all low
    rom_val = 8'd0;
    ticks(3 * 398, 4);
    chk("zero_switch_h", last_h, 2);
    chk("zero_switch_l", last_l, 1586);
    ticks(398, 4);
    chk("zero_h", last_h, 0);
    chk("zero_l", last_l, 1592);

    // Glitch: cmp=199, carrier 198->199->198 drops raw for one tick
    rom_val = 8'd199;
    ticks(2 * 398, 4);
    ticks(198, 4);
    chk("glitch_pre_carrier", int'(carrier), 198);
    chk("glitch_pre_h", int'(pwm_h), 1);
    chk("glitch_pre_addr", int'(sample_addr), 12);
    z0 = zero_cnt; l0 = l_cnt;
    ticks(2, 4);
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_dead_cycles", zero_cnt - z0, 8);
    chk("glitch_l_never", l_cnt - l0, 0);
    chk("glitch_back_h", int'(pwm_h), 1);

    // en=0 mid-period: parked on the next edge, ticks ignored
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("en0_h", int'(pwm_h), 0);
    chk("en0_l", int'(pwm_l), 0);
    chk("en0_carrier", int'(carrier), 0);
    chk("en0_addr", int'(sample_addr), 0);
    @(posedge clk); #1;
    ticks(1, 4);
    chk("en0_tick_ignored", int'(carrier), 0);
    chk("en0_no_ps", ps_cnt, 12);

    // Re-enable: shadow recaptured address 0 (199), active after one period
    en = 1'b1;
    ticks(398 + 10, 4);
    chk("reen_carrier", int'(carrier), 10);
    chk("reen_addr", int'(sample_addr), 1);
    chk("reen_h", int'(pwm_h), 1);

    // Asynchronous reset mid-H_ON
    #2 rst = 1'b1;
    #1;
    chk("arst_h", int'(pwm_h), 0);
    chk("arst_l", int'(pwm_l), 0);
    chk("arst_carrier", int'(carrier), 0);
    chk("arst_addr", int'(sample_addr), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Small instance: address wrap and one-period compare lag
    en2 = 1'b1;
    for (int i = 1; i <= 66; i++) begin
      ticks2(14, 4);
      chk($sformatf("wrap_addr%0d", i), int'(sample_addr2), i % 64);
      if (i == 65) chk("wrap_full_h", last_h2, 56);
      if (i == 66) begin
        chk("wrap_lag_h", last_h2, 2);
        chk("wrap_lag_l", last_l2, 50);
        chk("wrap_ps", ps2_cnt, 66);
      end
    end

    chk("no_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
